// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit pin between NREQ byte-stream
// requesters. Requesters are served round-robin. A requester that has not
// flagged the last byte of its packet keeps the line for up to MAX_BURST
// bytes, so its frames go out back to back.
// The same module holds the bit-timing counter and the serializer that drive
// the tx pin.
// Optional feature: define UART_TX_ARB_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, which gives 11-bit frames.
// Without the macro the frames are plain 8N1 (10 bits).

module uart_tx_arbiter #(
   parameter int FREQ      = 12000000,
   parameter int BAUD      = 9600,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic                tx,
   output logic                busy,
   output logic [2:0]          grant_id
);

   localparam int LIM = FREQ / BAUD;
   localparam int CW  = ($clog2(LIM) > 11) ? $clog2(LIM) : 11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      HOLD
`ifdef UART_TX_ARB_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t          state_reg;
   logic            tx_reg;
   logic            busy_reg;
   logic [2:0]      grant_reg;
   logic [2:0]      ptr_reg;
   logic [4:0]      burst_reg;
   logic            lock_reg;
   logic [CW-1:0]   cnt_reg;
   logic [2:0]      bit_reg;
   logic [7:0]      data_reg;

   // Requester signals padded to 8 slots so a 3-bit index always fits
   logic [7:0]      valid_pad;
   logic [7:0]      last_pad;
   logic [7:0]      byte_pad [8];

   logic            win_found;
   logic [2:0]      win_idx;
   logic [3:0]      idx_sum;
   logic [2:0]      cand;
   logic [2:0]      ptr_next;
   logic            take;
   logic [2:0]      take_idx;
   logic            cnt_last;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pad
         if (gi < NREQ) begin : g_real
            assign valid_pad[gi] = req_valid[gi];
            assign last_pad[gi]  = req_last[gi];
            assign byte_pad[gi]  = req_data[8*gi+7:8*gi];
         end else begin : g_none
            assign valid_pad[gi] = 1'b0;
            assign last_pad[gi]  = 1'b0;
            assign byte_pad[gi]  = 8'h00;
         end
      end
   endgenerate

   // Round-robin search: the loop runs from the farthest offset to offset 0,
   // so the last hit written is the one nearest to ptr
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      idx_sum   = 4'd0;
      cand      = 3'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx_sum = {1'b0, ptr_reg} + 4'(k);
         if (idx_sum >= 4'(NREQ)) begin
            idx_sum = idx_sum - 4'(NREQ);
         end
         cand = idx_sum[2:0];
         if (valid_pad[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Handshake selection: open arbitration in IDLE; in HOLD only the locked owner may send
   always_comb begin
      take     = 1'b0;
      take_idx = grant_reg;
      ptr_next = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
      if (state_reg == IDLE) begin
         take     = win_found;
         take_idx = win_idx;
      end else if (state_reg == HOLD) begin
         take     = valid_pad[grant_reg];
      end
   end

   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = take && (take_idx == 3'(gi));
      end
   endgenerate

   assign cnt_last = (cnt_reg == CW'(LIM - 1));

   // Arbitration, bit timing and serialization in one registered FSM
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_reg <= IDLE;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
         grant_reg <= 3'd0;
         ptr_reg   <= 3'd0;
         burst_reg <= 5'd0;
         lock_reg  <= 1'b0;
         cnt_reg   <= '0;
         bit_reg   <= 3'd0;
         data_reg  <= 8'h00;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (take) begin
                  data_reg  <= byte_pad[take_idx];
                  grant_reg <= take_idx;
                  ptr_reg   <= ptr_next;
                  burst_reg <= 5'd1;
                  lock_reg  <= ~last_pad[take_idx];
                  busy_reg  <= 1'b1;
                  tx_reg    <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (cnt_last) begin
                  cnt_reg   <= '0;
                  bit_reg   <= 3'd0;
                  tx_reg    <= data_reg[0];
                  state_reg <= DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (cnt_last) begin
                  cnt_reg <= '0;
                  if (bit_reg == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                     tx_reg    <= ^data_reg;
                     state_reg <= PARITY;
`else
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
`endif
                  end else begin
                     bit_reg <= bit_reg + 3'd1;
                     tx_reg  <= data_reg[bit_reg + 3'd1];
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: begin
               if (cnt_last) begin
                  cnt_reg   <= '0;
                  tx_reg    <= 1'b1;
                  state_reg <= STOP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt_last) begin
                  cnt_reg <= '0;
                  if (lock_reg && (burst_reg < 5'(MAX_BURST))) begin
                     state_reg <= HOLD;
                  end else begin
                     lock_reg  <= 1'b0;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            HOLD: begin
               if (take) begin
                  data_reg  <= byte_pad[grant_reg];
                  burst_reg <= burst_reg + 5'd1;
                  lock_reg  <= ~last_pad[grant_reg];
                  tx_reg    <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= START;
               end else if (cnt_last) begin
                  cnt_reg   <= '0;
                  lock_reg  <= 1'b0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign tx       = tx_reg;
   assign busy     = busy_reg;
   assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. The design runs with a short bit time
// (LIM = 16) to keep the run brief. Stimulus pushes the expected grants and
// frames into queues. Monitor processes decode req_ready and the tx line and
// pop those queues to compare.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   localparam int FREQ      = 12000000;
   localparam int BAUD      = 750000;
   localparam int LIM       = FREQ / BAUD;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 4;
`ifdef UART_TX_ARB_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FCYC = FBITS * LIM;
   localparam int BOUND = 20 * FCYC;

   typedef struct {
      logic [2:0] id;
      logic [7:0] data;
      bit         b2b;
   } exp_t;

   logic                clk = 1'b0;
   logic                nrst = 1'b0;
   logic [NREQ-1:0]     req_valid;
   logic [8*NREQ-1:0]   req_data;
   logic [NREQ-1:0]     req_last;
   logic [NREQ-1:0]     req_ready;
   logic                tx;
   logic                busy;
   logic [2:0]          grant_id;

   exp_t        exp_q[$];
   int          ready_q[$];
   logic [8:0]  src_q[NREQ][$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;

   uart_tx_arbiter #(
      .FREQ(FREQ), .BAUD(BAUD), .NREQ(NREQ), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .nrst(nrst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
   endfunction

   function automatic void fail_now(string name);
      n_checks++;
      $display("FAIL %s: got nothing usable, required the expected event (cycle %0d)", name, cyc);
   endfunction

   function automatic bit src_pending();
      bit p = 1'b0;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic send(int id, logic [7:0] data, logic last, bit expect_frame, bit b2b);
      exp_t e;
      src_q[id].push_back({last, data});
      ready_q.push_back(id);
      if (expect_frame) begin
         e.id = 3'(id); e.data = data; e.b2b = b2b;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1; nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1; nrst = 1'b1;
   endtask

   task automatic wait_ready(int id, output int hcyc);
      int t = 0;
      hcyc = -1;
      while (hcyc < 0 && t < BOUND) begin
         @(negedge clk);
         if (req_ready[id] === 1'b1) hcyc = cyc;
         t++;
      end
      if (hcyc < 0) fail_now("ready_timeout");
   endtask

   task automatic drain(string name);
      int t = 0;
      while (t < BOUND && (exp_q.size() != 0 || ready_q.size() != 0 ||
                           busy !== 1'b0 || src_pending())) begin
         @(negedge clk);
         t++;
      end
      if (t >= BOUND) fail_now(name);
   endtask

   // Requester model: shows the head of each byte queue and pops it once it is consumed
   initial begin
      logic [NREQ-1:0] consumed;
      req_valid = '0; req_last = '0; req_data = '0;
      forever begin
         @(negedge clk);
         consumed = nrst ? req_ready : '0;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (consumed[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               req_valid[i]        = 1'b1;
               req_data[8*i +: 8]  = src_q[i][0][7:0];
               req_last[i]         = src_q[i][0][8];
            end else begin
               req_valid[i]        = 1'b0;
               req_data[8*i +: 8]  = 8'h00;
               req_last[i]         = 1'b0;
            end
         end
      end
   end

   // Grant monitor: every ready pulse must be one-hot, backed by valid, and in the expected order
   initial begin
      forever begin
         @(negedge clk);
         if (nrst && req_ready != '0) begin
            int id;
            id = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
            check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            check("ready_needs_valid", 32'(req_ready & ~req_valid), 32'd0);
            if (ready_q.size() == 0) fail_now("ready_unexpected");
            else check("ready_order", id, ready_q.pop_front());
         end
      end
   end

   // Line monitor: decodes frames at mid-bit and checks them against the expected frames
   initial begin
      bit         active;
      int         rcnt, rstart, last_start, k;
      logic [2:0] rgid;
      logic [7:0] rbyte;
      logic       rstartbit;
      exp_t       e;
      active = 1'b0; rcnt = 0; rstart = 0; last_start = -100000;
      rgid = 3'd0; rbyte = 8'h00; rstartbit = 1'b1;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1'b1; rcnt = 0; rstart = cyc; rgid = grant_id;
            end
         end else begin
            rcnt++;
            if (rcnt % LIM == LIM / 2) begin
               k = rcnt / LIM;
               if (k == 0) rstartbit = tx;
               else if (k <= 8) rbyte[k-1] = tx;
`ifdef UART_TX_ARB_PARITY_EN
               else if (k == 9) check("frame_parity", 32'(tx), 32'(^rbyte));
`endif
               if (k == FBITS - 1) begin
                  $display("frame: grant %0d byte 0x%02h start cycle %0d", rgid, rbyte, rstart);
                  if (exp_q.size() == 0) begin
                     fail_now("frame_unexpected");
                  end else begin
                     e = exp_q.pop_front();
                     check("frame_start_bit", 32'(rstartbit), 32'd0);
                     check("frame_byte", 32'(rbyte), 32'(e.data));
                     check("frame_grant", 32'(rgid), 32'(e.id));
                     check("frame_stop_bit", 32'(tx), 32'd1);
                     if (e.b2b) check("frame_spacing", rstart - last_start, FCYC + 1);
                  end
                  last_start = rstart;
                  active = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #(100000 * 10);
      fail_now("global_timeout");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Directed scenarios
   initial begin
      int         h, bad, b;
      logic [10:0] wave;
      logic       exp_tx;

      // Reset values and a long quiet idle
      do_reset();
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_grant", 32'(grant_id), 32'd0);
      bad = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0) bad++;
      end
      check("idle_quiet_cycles_bad", bad, 0);

      // Single byte 0x53: exact waveform, LSB first, and the busy release cycle
      wave = '1;
      wave[0] = 1'b0;
      wave[8:1] = 8'h53;
`ifdef UART_TX_ARB_PARITY_EN
      wave[9] = 1'b0;
`endif
      wave[FBITS-1] = 1'b1;
      @(negedge clk);
      send(0, 8'h53, 1'b1, 1'b1, 1'b0);
      wait_ready(0, h);
      bad = 0;
      for (int c = 1; c <= FCYC + 1; c++) begin
         @(negedge clk);
         b = (c - 1) / LIM;
         exp_tx = (c <= FCYC) ? wave[b] : 1'b1;
         if (tx !== exp_tx) bad++;
         if (c == 1)        check("start_first_cycle_tx", 32'(tx), 32'd0);
         if (c == LIM)      check("start_last_cycle_tx", 32'(tx), 32'd0);
         if (c == LIM + 1)  check("bit0_first_cycle_tx", 32'(tx), 32'd1);
         if (c == FCYC)     check("busy_last_stop_cycle", 32'(busy), 32'd1);
         if (c == FCYC + 1) check("busy_after_frame", 32'(busy), 32'd0);
      end
      check("wave_0x53_bad_cycles", bad, 0);
      drain("drain_single");

      // All four requesters valid: grants go 0,1,2,3,0
      do_reset();
      @(negedge clk);
      send(0, 8'hA0, 1'b1, 1'b1, 1'b0);
      send(1, 8'hA1, 1'b1, 1'b1, 1'b1);
      send(2, 8'hA2, 1'b1, 1'b1, 1'b1);
      send(3, 8'hA3, 1'b1, 1'b1, 1'b1);
      send(0, 8'hA0, 1'b1, 1'b1, 1'b1);
      drain("drain_round_robin");

      // Locked 4-byte packet from requester 2; requester 1 waits until it ends
      do_reset();
      @(negedge clk);
      send(2, 8'h53, 1'b0, 1'b1, 1'b0);
      send(2, 8'h6E, 1'b0, 1'b1, 1'b1);
      send(2, 8'h61, 1'b0, 1'b1, 1'b1);
      send(2, 8'h70, 1'b1, 1'b1, 1'b1);
      wait_ready(2, h);
      send(1, 8'h11, 1'b1, 1'b1, 1'b1);
      drain("drain_burst_lock");

      // Burst cap: requester 3 never ends within 4 bytes, requester 0 cuts in
      do_reset();
      @(negedge clk);
      send(3, 8'h30, 1'b0, 1'b1, 1'b0);
      send(3, 8'h31, 1'b0, 1'b1, 1'b1);
      send(3, 8'h32, 1'b0, 1'b1, 1'b1);
      send(3, 8'h33, 1'b0, 1'b1, 1'b1);
      wait_ready(3, h);
      send(0, 8'h0F, 1'b1, 1'b1, 1'b1);
      ready_q.delete();
      ready_q.push_back(3); ready_q.push_back(3); ready_q.push_back(3);
      ready_q.push_back(0);
      send(3, 8'h34, 1'b0, 1'b0, 1'b0);
      send(3, 8'h35, 1'b1, 1'b0, 1'b0);
      begin
         exp_t e;
         e.id = 3'd3; e.data = 8'h34; e.b2b = 1'b1; exp_q.push_back(e);
         e.id = 3'd3; e.data = 8'h35; e.b2b = 1'b1; exp_q.push_back(e);
      end
      drain("drain_burst_cap");

      // Reset in the middle of a frame aborts it; a later request gets a full frame
      do_reset();
      @(negedge clk);
      send(2, 8'h00, 1'b1, 1'b0, 1'b0);
      wait_ready(2, h);
      repeat (3 * LIM) @(negedge clk);
      check("grant_before_abort", 32'(grant_id), 32'd2);
      @(posedge clk); #1; nrst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      check("abort_grant", 32'(grant_id), 32'd0);
      @(posedge clk); #1; nrst = 1'b1;
      bad = 0;
      for (int c = 0; c < 2 * FCYC; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("after_abort_quiet_bad", bad, 0);
      send(1, 8'h5A, 1'b1, 1'b1, 1'b0);
      drain("drain_after_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
